// File: rtl/piece_border_regs_if.sv
// piece_border_regs_if: handshake and data bus between the move datapath/controller and the border register bank.
interface piece_border_regs_if #(
    parameter int MEM_WIDTH = 10,
    parameter int WIDTH     = 8
);
    logic                       write_reg;
    logic                       is_load_fig;
    logic                       revert;
    logic [WIDTH-1:0]           figure;
    logic [MEM_WIDTH*WIDTH-1:0] new_border;
    logic [4*WIDTH-1:0]         new_rho_x;
    logic [4*WIDTH-1:0]         new_rho_y;
    logic [MEM_WIDTH*WIDTH-1:0] border;
    logic [4*WIDTH-1:0]         rho_x;
    logic [4*WIDTH-1:0]         rho_y;
    logic [WIDTH-1:0]           cur_fig;
    logic                       busy;
    logic                       spawn_done;
    logic                       game_over;

    modport master (
        output write_reg, is_load_fig, revert, figure, new_border, new_rho_x, new_rho_y,
        input  border, rho_x, rho_y, cur_fig, busy, spawn_done, game_over
    );
    modport slave (
        input  write_reg, is_load_fig, revert, figure, new_border, new_rho_x, new_rho_y,
        output border, rho_x, rho_y, cur_fig, busy, spawn_done, game_over
    );
endinterface

// File: rtl/piece_border_regs.sv
// piece_border_regs: column borders, falling-figure cells and figure code with spawn table, spawn check and game-over.
// PIECE_BORDER_REGS_SNAPSHOT_EN enables shadow coordinates and revert.
module piece_border_regs #(
    parameter int MEM_WIDTH  = 10,
    parameter int MEM_HEIGHT = 20,
    parameter int WIDTH      = 8,
    parameter int SPAWN_X    = 3
) (
    input logic              clk,
    input logic              rst,
    piece_border_regs_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

    // per figure: four nibbles {dx[1:0], dy[1:0]}, cell 0 in the top nibble
    localparam logic [15:0] TAB [7] = '{16'h0485, 16'h0412, 16'h0123, 16'h0415,
                                        16'h4815, 16'h0459, 16'h0456};

    state_t                     r_state;
    state_t                     w_next;
    logic [WIDTH-1:0]           r_border [MEM_WIDTH];
    logic [WIDTH-1:0]           r_rho_x [4];
    logic [WIDTH-1:0]           r_rho_y [4];
    logic [WIDTH-1:0]           w_sx [4];
    logic [WIDTH-1:0]           w_sy [4];
    logic [WIDTH-1:0]           r_cur_fig;
    logic                       r_spawn_done;
    logic                       r_game_over;
    logic [15:0]                w_tab;
    logic [3:0]                 w_safe;
    logic                       w_hit;
    logic                       w_busy;
    logic [MEM_WIDTH*WIDTH-1:0] w_border;
    logic [4*WIDTH-1:0]         w_rho_x;
    logic [4*WIDTH-1:0]         w_rho_y;
`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
    logic [WIDTH-1:0]           r_shadow_x [4];
    logic [WIDTH-1:0]           r_shadow_y [4];
`else
    logic                       w_unused;
    assign w_unused = bus.revert;
`endif

    always_comb begin
        w_tab = (bus.figure < WIDTH'(7)) ? TAB[bus.figure[2:0]] : 16'h0000;
        for (int j = 0; j < 4; j++) begin
            w_sx[j] = WIDTH'(SPAWN_X) + WIDTH'(w_tab[4*(3-j)+3 -: 2]);
            w_sy[j] = WIDTH'(w_tab[4*(3-j)+1 -: 2]);
        end
    end

    // a cell is safe only if it lands on an existing column above that column's border
    always_comb begin
        w_safe = '0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < MEM_WIDTH; i++)
                if (r_rho_x[j] == WIDTH'(i) && r_rho_y[j] < r_border[i]) w_safe[j] = 1'b1;
        w_hit = ~&w_safe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (bus.is_load_fig ? CHECK : IDLE) :
                 (r_state == CHECK) ? (w_hit ? OVER : IDLE) : OVER;
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_border = '0;
        w_rho_x = '0;
        w_rho_y = '0;
        for (int i = 0; i < MEM_WIDTH; i++) w_border[WIDTH*(MEM_WIDTH-i)-1 -: WIDTH] = r_border[i];
        for (int j = 0; j < 4; j++) begin
            w_rho_x[(4-j)*WIDTH-1 -: WIDTH] = r_rho_x[j];
            w_rho_y[(4-j)*WIDTH-1 -: WIDTH] = r_rho_y[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WIDTH; i++) r_border[i] <= WIDTH'(MEM_HEIGHT);
            for (int j = 0; j < 4; j++) begin
                r_rho_x[j] <= '0;
                r_rho_y[j] <= '0;
`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
                r_shadow_x[j] <= '0;
                r_shadow_y[j] <= '0;
`endif
            end
            r_cur_fig    <= '0;
            r_spawn_done <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_spawn_done <= (r_state == CHECK) && !w_hit;
            r_game_over  <= r_game_over | ((r_state == CHECK) && w_hit);
            if (r_state == IDLE) begin
`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
                if (bus.write_reg && (bus.is_load_fig || !bus.revert))
`else
                if (bus.write_reg)
`endif
                    for (int i = 0; i < MEM_WIDTH; i++)
                        r_border[i] <= bus.new_border[WIDTH*(MEM_WIDTH-i)-1 -: WIDTH];
                if (bus.is_load_fig) begin
                    r_cur_fig <= bus.figure;
                    for (int j = 0; j < 4; j++) begin
                        r_rho_x[j] <= w_sx[j];
                        r_rho_y[j] <= w_sy[j];
`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
                        r_shadow_x[j] <= w_sx[j];
                        r_shadow_y[j] <= w_sy[j];
`endif
                    end
                end
`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
                else if (bus.revert) begin
                    for (int j = 0; j < 4; j++) begin
                        r_rho_x[j] <= r_shadow_x[j];
                        r_rho_y[j] <= r_shadow_y[j];
                    end
                end
`endif
                else if (bus.write_reg) begin
                    for (int j = 0; j < 4; j++) begin
                        r_rho_x[j] <= bus.new_rho_x[(4-j)*WIDTH-1 -: WIDTH];
                        r_rho_y[j] <= bus.new_rho_y[(4-j)*WIDTH-1 -: WIDTH];
`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
                        r_shadow_x[j] <= r_rho_x[j];
                        r_shadow_y[j] <= r_rho_y[j];
`endif
                    end
                end
            end
        end
    end

    assign bus.border     = w_border;
    assign bus.rho_x      = w_rho_x;
    assign bus.rho_y      = w_rho_y;
    assign bus.cur_fig    = r_cur_fig;
    assign bus.busy       = w_busy;
    assign bus.spawn_done = r_spawn_done;
    assign bus.game_over  = r_game_over;
endmodule

// File: tb/tb_piece_border_regs.sv
// tb_piece_border_regs: spawn table vectors, hand corner sequences and randomized traffic against a transaction-level model.
module tb_piece_border_regs;
    localparam int MW = 10, MH = 20, W = 8, SX = 3, NT = 9;

    typedef struct packed {
        logic [7:0]  fig;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piece_border_regs_if #(.MEM_WIDTH(MW), .WIDTH(W)) bus ();
    piece_border_regs #(.MEM_WIDTH(MW), .MEM_HEIGHT(MH), .WIDTH(W), .SPAWN_X(SX)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int          checks = 0;
    int          failures = 0;
    vec_t        tab [NT];
    int          m_b [MW];
    logic [31:0] m_x, m_y;
    int          m_fig;
    bit          m_go;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW*W-1:0] pk_b();
        logic [MW*W-1:0] v = '0;
        for (int i = 0; i < MW; i++) v = (v << W) | (MW*W)'(m_b[i]);
        return v;
    endfunction

    function automatic logic [MW*W-1:0] mkb(input int col, input int val);
        logic [MW*W-1:0] v = '0;
        for (int i = 0; i < MW; i++) v = (v << W) | (MW*W)'((i == col) ? val : MH);
        return v;
    endfunction

    function automatic logic [MW*W-1:0] rand_b();
        logic [MW*W-1:0] v = '0;
        for (int i = 0; i < MW; i++)
            v = (v << W) | (MW*W)'($urandom_range(0, 1) ? $urandom_range(0, 4) : MH);
        return v;
    endfunction

    task automatic set_b(input logic [MW*W-1:0] b);
        for (int i = 0; i < MW; i++) m_b[i] = int'(b[W*(MW-i)-1 -: W]);
    endtask

    function automatic logic [63:0] exp_cells(input int f);
        for (int k = 0; k < NT; k++) if (int'(tab[k].fig) == f) return {tab[k].x, tab[k].y};
        return {32'h03030303, 32'h00000000};
    endfunction

    function automatic bit coll();
        for (int j = 0; j < 4; j++) begin
            int x = int'(m_x[(3-j)*8 +: 8]);
            int y = int'(m_y[(3-j)*8 +: 8]);
            if (x >= MW || y >= m_b[x]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MW; i++) m_b[i] = MH;
        m_x = '0;
        m_y = '0;
        m_fig = 0;
        m_go = 1'b0;
    endtask

    task automatic check_regs(input string name);
        check({name, "_border"}, bus.border, pk_b());
        check({name, "_rho_x"}, bus.rho_x, m_x);
        check({name, "_rho_y"}, bus.rho_y, m_y);
        check({name, "_cur_fig"}, bus.cur_fig, W'(m_fig));
    endtask

    task automatic check_flags(input string name, input bit busy, input bit done, input bit go);
        check({name, "_busy"}, bus.busy, busy);
        check({name, "_spawn_done"}, bus.spawn_done, done);
        check({name, "_game_over"}, bus.game_over, go);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_regs("rst");
        check_flags("rst", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [MW*W-1:0] b, input logic [31:0] x, input logic [31:0] y);
        bus.write_reg = 1'b1;
        bus.new_border = b;
        bus.new_rho_x = x;
        bus.new_rho_y = y;
`ifndef PIECE_BORDER_REGS_SNAPSHOT_EN
        bus.revert = 1'($urandom_range(0, 1));
`endif
        step();
        bus.write_reg = 1'b0;
        bus.revert = 1'b0;
        if (!m_go) begin
            set_b(b);
            m_x = x;
            m_y = y;
        end
        check_regs("wr");
        check("wr_busy", bus.busy, m_go);
    endtask

    task automatic spawn(input int f, input bit wr_same, input bit wr_chk);
        logic [MW*W-1:0] b = rand_b();
        bit c;
        bus.is_load_fig = 1'b1;
        bus.figure = W'(f);
        bus.write_reg = wr_same;
        bus.new_border = b;
        bus.new_rho_x = $urandom;
        bus.new_rho_y = $urandom;
        step();
        bus.is_load_fig = wr_chk;
        bus.write_reg = wr_chk;
        bus.new_border = rand_b();
        bus.new_rho_x = $urandom;
        bus.new_rho_y = $urandom;
        if (wr_same) set_b(b);
        {m_x, m_y} = exp_cells(f);
        m_fig = f;
        check_regs("spawn");
        check_flags("spawn_t", 1'b1, 1'b0, 1'b0);
        c = coll();
        step();
        bus.is_load_fig = 1'b0;
        bus.write_reg = 1'b0;
        m_go = c;
        check_regs("spawn_chk");
        check_flags("spawn_t1", c, !c, c);
    endtask

    initial begin
        bus.write_reg = 1'b0;
        bus.is_load_fig = 1'b0;
        bus.revert = 1'b0;
        bus.figure = '0;
        bus.new_border = '0;
        bus.new_rho_x = '0;
        bus.new_rho_y = '0;
        tab[0] = {8'd0, 32'h03040504, 32'h00000001};
        tab[1] = {8'd1, 32'h03040303, 32'h00000102};
        tab[2] = {8'd2, 32'h03030303, 32'h00010203};
        tab[3] = {8'd3, 32'h03040304, 32'h00000101};
        tab[4] = {8'd4, 32'h04050304, 32'h00000101};
        tab[5] = {8'd5, 32'h03040405, 32'h00000101};
        tab[6] = {8'd6, 32'h03040404, 32'h00000102};
        tab[7] = {8'd7, 32'h03030303, 32'h00000000};
        tab[8] = {8'd9, 32'h03030303, 32'h00000000};
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // asynchronous reset asserted between edges
        wr(rand_b(), $urandom, $urandom);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 model_reset();
        check_regs("async");
        check_flags("async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NT; k++) begin
            do_reset();
            spawn(int'(tab[k].fig), 1'b0, 1'b0);
        end

        // I piece next to a low column, then onto one
        do_reset();
        wr(mkb(4, 1), 32'h0, 32'h0);
        spawn(2, 1'b0, 1'b0);
        wr(mkb(3, 2), 32'h0, 32'h0);
        spawn(2, 1'b0, 1'b0);
        check("over_flag", bus.game_over, 1'b1);
        wr(rand_b(), $urandom, $urandom);
        bus.is_load_fig = 1'b1;
        bus.figure = 8'd0;
        step();
        bus.is_load_fig = 1'b0;
        check_regs("over_spawn");
        check_flags("over", 1'b1, 1'b0, 1'b1);

        do_reset();
        spawn(9, 1'b0, 1'b1);

        // reset while the spawn check is pending
        do_reset();
        bus.is_load_fig = 1'b1;
        bus.figure = 8'd0;
        step();
        bus.is_load_fig = 1'b0;
        #2 rst = 1'b1;
        #1 check_flags("rst_chk", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        check_regs("rst_chk_after");
        check_flags("rst_chk_after", 1'b0, 1'b0, 1'b0);

`ifdef PIECE_BORDER_REGS_SNAPSHOT_EN
        do_reset();
        spawn(0, 1'b0, 1'b0);
        wr(mkb(0, MH), 32'h03040504, 32'h01010102);
        bus.revert = 1'b1;
        step();
        bus.revert = 1'b0;
        m_y = 32'h00000001;
        check_regs("revert");
        wr(mkb(0, MH), 32'h03040504, 32'h05050505);
        bus.revert = 1'b1;
        bus.write_reg = 1'b1;
        bus.new_rho_x = 32'h01010101;
        bus.new_rho_y = 32'h07070707;
        step();
        bus.revert = 1'b0;
        bus.write_reg = 1'b0;
        check("revert_wr_x", bus.rho_x, 32'h03040504);
        check("revert_wr_y", bus.rho_y, 32'h00000001);
`endif

        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_go) do_reset();
            if ($urandom_range(0, 2) == 0) wr(rand_b(), $urandom, $urandom);
            else spawn(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
